// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES osc_clk cycles and publishes a saturating count with a valid strobe.
`timescale 1ns/1ps
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             osc_clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             ovf
);
    localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]    freq_q, freq_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    logic                edge_s;
    logic                cnt_sat_s;
    logic [CNT_W-1:0]    edge_cnt_nx_s;
    logic                ovf_flag_nx_s;

    // Synchronizer and history stage for the asynchronous input
    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Edge count including this cycle's edge, saturating; an edge while full flags overflow
    always_comb begin
        edge_s        = s2_q & ~s3_q;
        cnt_sat_s     = (edge_cnt_q == CNT_MAX);
        edge_cnt_nx_s = edge_cnt_q;
        ovf_flag_nx_s = ovf_flag_q;
        if (edge_s) begin
            edge_cnt_nx_s = cnt_sat_s ? edge_cnt_q : (edge_cnt_q + CNT_W'(1));
            ovf_flag_nx_s = ovf_flag_q | cnt_sat_s;
        end else begin
            edge_cnt_nx_s = edge_cnt_q;
            ovf_flag_nx_s = ovf_flag_q;
        end
    end

    // Window FSM: next state, counters and published result
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_flag_d = ovf_flag_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gate_cnt_d = {GATE_W{1'b0}};
                edge_cnt_d = {CNT_W{1'b0}};
                ovf_flag_d = 1'b0;
                if (en) begin
                    state_d = ST_GATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    // Closing cycle: publish, then restart immediately if still enabled
                    freq_d     = edge_cnt_nx_s;
                    ovf_d      = ovf_flag_nx_s;
                    valid_d    = 1'b1;
                    gate_cnt_d = {GATE_W{1'b0}};
                    edge_cnt_d = {CNT_W{1'b0}};
                    ovf_flag_d = 1'b0;
                    state_d    = en ? ST_GATE : ST_IDLE;
                end else if (!en) begin
                    gate_cnt_d = {GATE_W{1'b0}};
                    edge_cnt_d = {CNT_W{1'b0}};
                    ovf_flag_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_cnt_nx_s;
                    ovf_flag_d = ovf_flag_nx_s;
                    state_d    = ST_GATE;
                end
            end
            default: begin
                gate_cnt_d = {GATE_W{1'b0}};
                edge_cnt_d = {CNT_W{1'b0}};
                ovf_flag_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge osc_clk) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            gate_cnt_q <= {GATE_W{1'b0}};
            edge_cnt_q <= {CNT_W{1'b0}};
            ovf_flag_q <= 1'b0;
            freq_q     <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_flag_q <= ovf_flag_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign freq  = freq_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (8-bit and 4-bit counters) share stimulus and
// are compared every cycle against an integer window-count reference model.
`timescale 1ns/1ps
module tb_freq_meter;
    localparam int G = 100;

    logic       osc_clk = 1'b0;
    logic       clr     = 1'b0;
    logic       en      = 1'b0;
    logic       sig_in  = 1'b0;
    logic [7:0] freq8;
    logic       valid8, ovf8;
    logic [3:0] freq4;
    logic       valid4, ovf4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: recent sampled input values, window progress, raw edge total
    bit h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    bit m_active = 1'b0;
    int m_pos = 0, m_n = 0, m_freq8 = 0, m_freq4 = 0;
    bit m_ovf8 = 1'b0, m_ovf4 = 1'b0, m_valid = 1'b0;

    int sq_half = 0;
    int ph      = 0;
    bit rnd_sig = 1'b0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u_dut8 (
        .osc_clk(osc_clk), .clr(clr), .en(en), .sig_in(sig_in),
        .freq(freq8), .valid(valid8), .ovf(ovf8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) u_dut4 (
        .osc_clk(osc_clk), .clr(clr), .en(en), .sig_in(sig_in),
        .freq(freq4), .valid(valid4), .ovf(ovf4)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Edge seen by the meter at this clock: input rose two samples ago
    task automatic model_tick();
        bit e;
        e = h1 & ~h2;
        m_valid = 1'b0;
        if (!clr) begin
            m_active = 1'b0; m_pos = 0; m_n = 0;
            m_freq8 = 0; m_freq4 = 0; m_ovf8 = 1'b0; m_ovf4 = 1'b0;
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        end else begin
            if (!m_active) begin
                m_active = en; m_pos = 0; m_n = 0;
            end else begin
                m_n += int'(e);
                if (m_pos == G - 1) begin
                    m_freq8 = (m_n > 255) ? 255 : m_n;
                    m_ovf8  = (m_n > 255);
                    m_freq4 = (m_n > 15) ? 15 : m_n;
                    m_ovf4  = (m_n > 15);
                    m_valid = 1'b1;
                    m_n = 0; m_pos = 0; m_active = en;
                end else if (!en) begin
                    m_active = 1'b0; m_pos = 0; m_n = 0;
                end else begin
                    m_pos++;
                end
            end
            h2 = h1; h1 = h0; h0 = sig_in;
        end
    endtask

    task automatic step();
        if (sq_half > 0) begin
            if (ph >= sq_half - 1) begin
                sig_in = ~sig_in;
                ph = 0;
            end else begin
                ph++;
            end
        end else if (rnd_sig) begin
            sig_in = ($urandom_range(0, 1) == 1);
        end
        model_tick();
        @(posedge osc_clk);
        #1;
        check_eq("freq8",  32'(freq8),  32'(m_freq8));
        check_eq("ovf8",   32'(ovf8),   32'(m_ovf8));
        check_eq("valid8", 32'(valid8), 32'(m_valid));
        check_eq("freq4",  32'(freq4),  32'(m_freq4));
        check_eq("ovf4",   32'(ovf4),   32'(m_ovf4));
        check_eq("valid4", 32'(valid4), 32'(m_valid));
    endtask

    task automatic set_sq(input int half);
        sq_half = half;
        ph      = 0;
        rnd_sig = 1'b0;
    endtask

    // Step until valid shows on the 8-bit instance (bounded) and check the step count
    task automatic wait_valid(input string tag, input int exp_k);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (valid8 !== 1'b1 && k < 300);
        check_eq(tag, 32'(k), 32'(exp_k));
    endtask

    initial begin
        // Reset held with enable and a toggling input
        clr = 1'b0; en = 1'b1; set_sq(1);
        repeat (3) step();
        check_eq("rst_freq",  32'(freq8),  32'd0);
        check_eq("rst_valid", 32'(valid8), 32'd0);
        check_eq("rst_ovf",   32'(ovf8),   32'd0);

        // Steady period-10 input
        set_sq(5);
        clr = 1'b1;
        wait_valid("first_valid_lat", 101);
        for (int w = 0; w < 3; w++) begin
            wait_valid("steady_period", 100);
            check_eq("steady_freq8", 32'(freq8), 32'd10);
            check_eq("steady_ovf8",  32'(ovf8),  32'd0);
            check_eq("steady_freq4", 32'(freq4), 32'd10);
        end

        // No activity
        set_sq(0); sig_in = 1'b0;
        wait_valid("idle_sig_period", 100);
        wait_valid("idle_sig_period", 100);
        check_eq("idle_sig_freq", 32'(freq8), 32'd0);

        // Abort at window cycle 50
        set_sq(5);
        wait_valid("restore_period", 100);
        wait_valid("restore_period", 100);
        check_eq("restore_freq", 32'(freq8), 32'd10);
        repeat (50) step();
        en = 1'b0;
        repeat (5) step();
        check_eq("abort_hold", 32'(freq8), 32'd10);
        en = 1'b1;
        wait_valid("abort_relat", 101);
        check_eq("abort_freq", 32'(freq8), 32'd10);

        // Saturation on the 4-bit counter
        set_sq(1);
        wait_valid("sat_period", 100);
        wait_valid("sat_period", 100);
        check_eq("sat_freq4", 32'(freq4), 32'd15);
        check_eq("sat_ovf4",  32'(ovf4),  32'd1);
        check_eq("sat_freq8", 32'(freq8), 32'd50);
        check_eq("sat_ovf8",  32'(ovf8),  32'd0);
        set_sq(5);
        wait_valid("unsat_period", 100);
        wait_valid("unsat_period", 100);
        check_eq("unsat_freq4", 32'(freq4), 32'd10);
        check_eq("unsat_ovf4",  32'(ovf4),  32'd0);

        // Reset in the middle of a window
        repeat (60) step();
        clr = 1'b0;
        step();
        check_eq("midrst_freq",  32'(freq8),  32'd0);
        check_eq("midrst_ovf",   32'(ovf4),   32'd0);
        check_eq("midrst_valid", 32'(valid8), 32'd0);
        clr = 1'b1;
        wait_valid("midrst_relat", 101);

        // Randomized segments: input shape, enable drops, occasional reset
        for (int seg = 0; seg < 20; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                set_sq(int'($urandom_range(1, 8)));
            end else if (mode == 1) begin
                sq_half = 0; rnd_sig = 1'b1;
            end else begin
                sq_half = 0; rnd_sig = 1'b0; sig_in = 1'b0;
            end
            for (int c = 0; c < 200; c++) begin
                clr = ($urandom_range(0, 499) != 0);
                if (en && $urandom_range(0, 299) == 0) begin
                    en = 1'b0;
                end else if (!en && $urandom_range(0, 9) == 0) begin
                    en = 1'b1;
                end
                step();
            end
        end
        clr = 1'b1; en = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated-window frequency meter: counts rising edges of an asynchronous input over a fixed window of `osc_clk` cycles and reports the count once per window. It is the measuring counterpart of the frequency divider: the divider produces a slow clock from `osc_clk`, and this block checks a slow clock (divider output or any external signal) against `osc_clk`. It runs back-to-back windows while enabled and presents a registered result with a one-cycle valid strobe.

## Interface
- `GATE_CYCLES`, default 50000000: window length in `osc_clk` cycles (≥2); 1 s at 50 MHz.
- `CNT_W`, default 32: width of the edge counter and of `freq`.
- `osc_clk`  in  1  system clock; all logic on its rising edge.
- `clr`  in  1  reset, synchronous, active-low.
- `en`  in  1  measurement enable, synchronous.
- `sig_in`  in  1  signal under measurement, asynchronous to `osc_clk`.
- `freq`  out  CNT_W  rising-edge count of the last completed window, saturating.
- `valid`  out  1  one-cycle pulse when `freq`/`ovf` update.
- `ovf`  out  1  last completed window saturated the edge counter.

## Operation
- Input path: two-flop synchronizer (`s1`, `s2`), then history flop `s3`; `edge = s2 & ~s3`. All three reset to 0.
- Gate counter width: ceil(log2(GATE_CYCLES)) bits, counts 0..GATE_CYCLES-1.
- FSM, two states:
  - IDLE: gate and edge counters held at 0, internal overflow flag cleared. If `en`=1, go to GATE.
  - GATE: gate counter +1 per cycle. Edge counter +1 when `edge`=1, saturating at 2^CNT_W-1; an edge while saturated sets the internal overflow flag.
  - GATE, last cycle (gate counter = GATE_CYCLES-1): `freq` <= edge count including this cycle's edge (saturating); `ovf` <= internal flag, or saturation caused this cycle; `valid` <= 1. Counters and flag cleared. Stay in GATE if `en`=1, else go to IDLE.
  - GATE with `en`=0 before the last cycle: abort. Go to IDLE, counters cleared, `freq`/`ovf` unchanged, no `valid`.
- `freq`/`ovf` change only on window completion or reset.
- Resolution: at most one edge per two `osc_clk` cycles; a high or low phase shorter than one cycle may be missed.

## Timing
- Reset (`clr`=0 sampled at an edge): next cycle `freq`=0, `valid`=0, `ovf`=0, state IDLE, counters and sync flops 0. This overrides `en` and any window in progress.
- `sig_in` rising edge to `edge` assertion: 2-3 cycles (synchronizer plus history flop).
- `en`=1 sampled in IDLE at edge N: GATE from cycle N+1. The window covers cycles N+1..N+GATE_CYCLES.
- `valid` is high for exactly the one cycle after the last window cycle, together with the new `freq`/`ovf`.
- Back-to-back windows have no dead cycle. The next window's first counted cycle is the cycle in which `valid`=1.
- `edge` in the last window cycle counts toward the closing window. `edge` in the `valid` cycle counts toward the next window.
- `sig_in` held high through reset release produces one edge (sync flops reset to 0). It is counted only if it lands inside a window.

## Test plan
- Reset: `clr`=0 for 3 cycles with `en`=1 and `sig_in` toggling -> `freq`=0, `valid`=0, `ovf`=0 throughout; no `valid` until GATE_CYCLES+1 cycles after `clr` release with `en`=1.
- Steady count: GATE_CYCLES=100, CNT_W=8, `sig_in` period 10 cycles (5 low/5 high, first rise 5 cycles into the window), `en`=1 -> `valid` every 100 cycles, `freq`=10, `ovf`=0, for at least 3 windows.
- No activity: `sig_in`=0 constant -> `valid` still pulses every 100 cycles with `freq`=0.
- Abort: after a `freq`=10 window, drop `en` at window cycle 50 for 5 cycles, then re-assert -> no `valid` for the aborted window, `freq` holds 10; the next `valid` arrives 101 cycles after `en` is re-sampled high, with `freq`=10.
- Saturation: CNT_W=4, `sig_in` period 2 -> `freq`=15, `ovf`=1. Then switch to period 10 -> next full window gives `freq`=10, `ovf`=0.
- Reset mid-window: `clr`=0 at window cycle 60 after `freq`=10 -> next cycle `freq`=0, `ovf`=0, no `valid`; measurement restarts from IDLE after release.
